// File: rtl/seq_pkg.sv
// Shared types and defaults for the framed serial-detector arbiter.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CLR  = 2'd2
   } state_t;

   localparam int N_DEF     = 4;
   localparam int CNT_W_DEF = 8;

   function automatic int owner_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_core.sv
// Two-flop serial detector: s1' = a^s0^s1, s0' = ~s0, y = s0'&s1'.
// The y output is registered one cycle after an enabled bit; y_nxt is the same result, combinationally.
module seq_core (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic a,
   output logic y_nxt,
   output logic y
);

   logic s0, s1;
   logic s0_nxt, s1_nxt;

   always_comb begin
      s1_nxt = a ^ s0 ^ s1;
      s0_nxt = ~s0;
      y_nxt  = s0_nxt & s1_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         y  <= 1'b0;
      end else begin
         y <= en & y_nxt;
         if (clr) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
         end else if (en) begin
            s0 <= s0_nxt;
            s1 <= s1_nxt;
         end
      end
   end

endmodule

// File: rtl/seq_stream_arbiter.sv
// Round-robin, per-frame sharing of one seq_core among N serial requesters.
// Emits owner-tagged per-bit results and a saturating per-frame hit count.
module seq_stream_arbiter
   import seq_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N-1:0]            req,
   input  logic [N-1:0]            bit_valid,
   input  logic [N-1:0]            bit_a,
   input  logic [N-1:0]            bit_last,
   output logic [N-1:0]            bit_ready,
   output logic [N-1:0]            gnt,
   output logic                    y_valid,
   output logic                    y,
   output logic [owner_w(N)-1:0]   y_owner,
   output logic                    frame_done,
   output logic                    frame_abort,
   output logic [CNT_W-1:0]        frame_hits
);

   localparam int OW = owner_w(N);
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [OW-1:0]    owner, rr, pick, idx;
   logic             pick_vld;
   logic             consume, done, abort, start, core_clr, core_y_nxt;
   logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;

   // First requester at or after the round-robin pointer.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = OW'((int'(rr) + i) % N);
         if (req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld) state_nxt = RUN;
         RUN:     if (done || abort) state_nxt = CLR;
         CLR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A req drop blocks consumption, so last-bit plus drop resolves to an abort.
   always_comb begin
      consume          = (state == RUN) & gnt[owner] & bit_valid[owner] & req[owner];
      done             = consume & bit_last[owner];
      abort            = (state == RUN) & ~req[owner];
      start            = (state == IDLE) & pick_vld;
      core_clr         = start | (state == CLR);
      bit_ready        = '0;
      bit_ready[owner] = consume;
   end

   seq_core u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (core_clr),
      .en    (consume),
      .a     (bit_a[owner]),
      .y_nxt (core_y_nxt),
      .y     (y)
   );

   always_comb begin
      cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
      cnt_nxt = core_y_nxt ? cnt_inc : cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt         <= '0;
         owner       <= '0;
         rr          <= '0;
         cnt         <= '0;
         y_valid     <= 1'b0;
         y_owner     <= '0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         frame_hits  <= '0;
      end else begin
         y_valid     <= consume;
         frame_done  <= done;
         frame_abort <= abort;
         frame_hits  <= '0;
         if (consume) y_owner <= owner;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  gnt   <= ONE << pick;
                  owner <= pick;
                  cnt   <= '0;
               end
            end
            RUN: begin
               if (consume) cnt <= cnt_nxt;
               if (done)  frame_hits <= cnt_nxt;
               if (abort) frame_hits <= cnt;
            end
            CLR: begin
               gnt <= '0;
               rr  <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_stream_arbiter.sv
// Randomized and directed bench for seq_stream_arbiter against a frame-level reference model.
module tb_seq_stream_arbiter;
   import seq_pkg::*;

   localparam int N     = 4;
   localparam int CNT_W = 2;
   localparam int HMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req, bit_valid, bit_a, bit_last, bit_ready, gnt;
   logic             y_valid, y, frame_done, frame_abort;
   logic [1:0]       y_owner;
   logic [CNT_W-1:0] frame_hits;

   seq_stream_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .bit_valid(bit_valid), .bit_a(bit_a),
      .bit_last(bit_last), .bit_ready(bit_ready), .gnt(gnt), .y_valid(y_valid),
      .y(y), .y_owner(y_owner), .frame_done(frame_done), .frame_abort(frame_abort),
      .frame_hits(frame_hits)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Source-side frames: bits LSB first; fab = consumed-bit count after which the source drops req.
   logic [15:0] fbits [N];
   int flen [N], fpos [N], fab [N];
   int vpct = 100;
   bit rnd = 0, fill1 = 0;

   // Reference model state (frame level).
   int own, start_own, rr, free_at, cyc = 0;
   bit ms0, ms1;
   int mhits;
   logic [N-1:0] eg;
   bit eyv, ey, edone, eabort;
   int eown, ehits;

   // Observation logs for directed checks.
   logic [31:0] ylog;
   int ny, nd, na, dhits, ahits, dcyc, zcyc;
   int glog [$];
   logic [N-1:0] pg = '0;

   function automatic void mdl_reset();
      own = -1; start_own = -1; rr = 0; free_at = 0;
      ms0 = 0; ms1 = 0; mhits = 0; eg = '0;
      eyv = 0; ey = 0; edone = 0; eabort = 0; eown = 0; ehits = 0;
   endfunction

   function automatic void clear_logs();
      ylog = '0; ny = 0; nd = 0; na = 0; dhits = -1; ahits = -1; dcyc = -1; zcyc = -1;
      glog.delete();
   endfunction

   function automatic bit busy();
      for (int i = 0; i < N; i++) if (flen[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load(input int i, input logic [15:0] b, input int len, input int ab);
      fbits[i] = b; flen[i] = len; fpos[i] = 0; fab[i] = ab;
   endtask

   task automatic drive();
      bit has, drop;
      for (int i = 0; i < N; i++) begin
         if (flen[i] == 0 && fill1) load(i, 16'($urandom), 1, -1);
         if (flen[i] == 0 && rnd && $urandom_range(0, 3) == 0) begin
            flen[i] = int'($urandom_range(1, 16));
            fbits[i] = 16'($urandom);
            fpos[i] = 0;
            fab[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, flen[i] - 1)) : -1;
         end
         has  = flen[i] > 0;
         drop = has && fab[i] >= 0 && fpos[i] >= fab[i] && gnt[i];
         req[i]       = has && !drop;
         bit_valid[i] = has && ($urandom_range(0, 99) < vpct);
         bit_a[i]     = fbits[i][fpos[i]];
         bit_last[i]  = has && (fpos[i] == flen[i] - 1);
         if (drop) flen[i] = 0;
      end
   endtask

   task automatic step();
      logic [N-1:0] erdy;
      int p;
      bit n0, n1;
      @(posedge clk); #1; cyc++;
      chk("gnt", gnt, eg);
      chk("y_valid", y_valid, eyv);
      if (eyv) begin
         chk("y", y, ey);
         chk("y_owner", y_owner, eown);
      end
      chk("frame_done", frame_done, edone);
      chk("frame_abort", frame_abort, eabort);
      if (edone || eabort) chk("frame_hits", frame_hits, ehits);
      if (gnt != 0 && pg == 0) for (int j = 0; j < N; j++) if (gnt[j]) glog.push_back(j);
      if (gnt == 0 && pg != 0) zcyc = cyc;
      pg = gnt;
      if (y_valid && ny < 32) begin ylog[ny] = y; ny++; end
      if (frame_done)  begin nd++; dhits = int'(frame_hits); dcyc = cyc; end
      if (frame_abort) begin na++; ahits = int'(frame_hits); end
      if (start_own >= 0) begin own = start_own; start_own = -1; end

      drive();
      #1;

      erdy = '0; eg = '0;
      eyv = 0; ey = 0; edone = 0; eabort = 0; ehits = 0;
      if (own >= 0) begin
         eg[own] = 1'b1;
         if (req[own] && bit_valid[own]) begin
            n1 = bit_a[own] ^ ms0 ^ ms1;
            n0 = !ms0;
            ms0 = n0; ms1 = n1;
            erdy[own] = 1'b1;
            eyv = 1; ey = n0 & n1; eown = own;
            if (ey && mhits < HMAX) mhits++;
            if (bit_last[own]) begin edone = 1; ehits = mhits; end
         end else if (!req[own]) begin
            eabort = 1; ehits = mhits;
         end
         if (edone || eabort) begin
            rr = (own + 1) % N; free_at = cyc + 2; own = -1;
         end
      end else if (start_own < 0 && cyc >= free_at && req != 0) begin
         p = 0;
         for (int j = N - 1; j >= 0; j--) if (req[(rr + j) % N]) p = (rr + j) % N;
         start_own = p; eg[p] = 1'b1;
         ms0 = 0; ms1 = 0; mhits = 0;
      end
      chk("bit_ready", bit_ready, erdy);

      for (int i = 0; i < N; i++) begin
         if (bit_ready[i]) begin
            fpos[i]++;
            if (fpos[i] >= flen[i]) flen[i] = 0;
         end
      end
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while (busy() && n < max) begin step(); n++; end
      if (busy()) chk("drain_timeout", 1, 0);
      repeat (4) step();
   endtask

   task automatic apply_reset();
      #3; rst_n = 1'b0; #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_bit_ready", bit_ready, 0);
      chk("rst_outs", {y_valid, y, y_owner, frame_done, frame_abort, frame_hits}, 0);
      for (int i = 0; i < N; i++) flen[i] = 0;
      req = '0; bit_valid = '0; bit_a = '0; bit_last = '0; pg = '0;
      mdl_reset();
      @(posedge clk); #2; rst_n = 1'b1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < N; i++) begin fbits[i] = '0; flen[i] = 0; fpos[i] = 0; fab[i] = -1; end
      req = '0; bit_valid = '0; bit_a = '0; bit_last = '0;
      rst_n = 1'b1;
      mdl_reset(); clear_logs();
      apply_reset();

      // Requester 0, bits 1,1,0,1.
      clear_logs(); load(0, 16'b1011, 4, -1); run_idle(100);
      chk("t1_y_seq", ylog[3:0], 4'b0101);
      chk("t1_ny", ny, 4);
      chk("t1_hits", dhits, 2);
      chk("t1_done", nd, 1);

      // Requester 2, bits 0,0,0,0; gnt drops two cycles after the last bit.
      clear_logs(); load(2, 16'h0000, 4, -1); run_idle(100);
      chk("t2_y_seq", ylog[3:0], 4'b0100);
      chk("t2_hits", dhits, 1);
      chk("t2_gnt_drop", zcyc - dcyc, 1);

      // Reset in the middle of a long frame.
      clear_logs(); load(2, 16'hffff, 16, -1);
      repeat (6) step();
      apply_reset();
      repeat (3) step();
      chk("rst_no_pulse", nd + na, 0);

      // All four requesting 1-bit frames: strict round-robin from pointer 0.
      clear_logs(); fill1 = 1; n = 0;
      while (glog.size() < 5 && n < 100) begin step(); n++; end
      fill1 = 0;
      run_idle(100);
      chk("t3_ngrants", (glog.size() >= 5), 1);
      if (glog.size() >= 5) begin
         chk("t3_g0", glog[0], 0);
         chk("t3_g1", glog[1], 1);
         chk("t3_g2", glog[2], 2);
         chk("t3_g3", glog[3], 3);
         chk("t3_g4", glog[4], 0);
      end

      // Requester 1 drops req after bits 1,1; requester 3 is next.
      clear_logs(); load(1, 16'h0003, 4, 2); load(3, 16'h0005, 3, -1); run_idle(100);
      chk("t4_abort", na, 1);
      chk("t4_abort_hits", ahits, 1);
      chk("t4_done", nd, 1);
      chk("t4_ngrants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t4_first", glog[0], 1);
         chk("t4_next", glog[1], 3);
      end

      // Same 1,1,0,1 frame with bit_valid gaps.
      clear_logs(); vpct = 50; load(0, 16'b1011, 4, -1); run_idle(200);
      chk("t5_y_seq", ylog[3:0], 4'b0101);
      chk("t5_ny", ny, 4);
      chk("t5_hits", dhits, 2);

      // Random traffic with stalls, aborts and saturating counts.
      vpct = 70; rnd = 1;
      repeat (3000) step();
      rnd = 0;
      run_idle(2000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_stream_arbiter.md
Name: seq_stream_arbiter

Overview:
Shares one two-flop serial detector core among N requesters, each sending a framed serial bit stream. Per bit, the core computes: s1' = a^s0^s1, s0' = ~s0, y = s0'&s1'. Arbitration is round-robin and per frame. The block clears core state at each frame start, returns per-bit results tagged with the owner, and reports a per-frame hit count. It sits between the serial sources and downstream result consumers in the basic sequential-circuit area.

Parameters:
N, 4, number of requesters (2..8)
CNT_W, 8, width of the per-frame hit counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  requester i wants or holds the core for a frame
bit_valid  in  N  requester i presents a bit this cycle
bit_a  in  N  serial data bit of requester i
bit_last  in  N  marks the final bit of requester i's frame
bit_ready  out  N  one-hot; bit of owner consumed this cycle
gnt  out  N  one-hot grant, registered
y_valid  out  1  result valid, registered
y  out  1  per-bit result s0'&s1'
y_owner  out  $clog2(N)  index of the owner of y
frame_done  out  1  one-cycle pulse after the last bit of a frame
frame_abort  out  1  one-cycle pulse when the owner drops req mid-frame
frame_hits  out  CNT_W  count of y=1 in the finished frame; valid with frame_done or frame_abort

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, rr pointer=0, s0=s1=0, hit counter=0. All outputs 0: gnt, bit_ready, y_valid, y, y_owner, frame_done, frame_abort, frame_hits.
- FSM states: IDLE, RUN, CLR.
- IDLE:
  - If any req bit is set, pick the first requester at or after the rr pointer, wrapping modulo N.
  - Register gnt and owner; clear s0, s1 and the hit counter; go to RUN.
  - Grant latency is 1 cycle from req to gnt.
- RUN:
  - bit_ready[owner] = gnt[owner] & bit_valid[owner] & req[owner]. This is combinational.
  - Bits from non-owners are ignored.
  - On a consumed bit, update s0/s1. Next cycle: y_valid=1, y=s0'&s1', y_owner=owner. Result latency is 1 cycle.
  - If y=1, hit counter += 1, saturating at 2^CNT_W-1.
  - A consumed bit with bit_last set: go to CLR.
    - Next cycle, frame_done=1 and frame_hits = final count, which includes the last bit's y.
  - req[owner]=0 with no bit consumed: abort and go to CLR.
    - Next cycle, frame_abort=1 and frame_hits = partial count.
  - If bit_last and the req drop occur in the same cycle, bit_ready is 0, so the result is an abort.
- CLR (1 cycle):
  - Deassert gnt.
  - Set rr pointer = owner+1, wrapping modulo N.
  - Clear s0 and s1.
  - Go to IDLE.
  - Minimum gap between frames is 2 cycles (CLR then IDLE), giving strict round-robin fairness.
- Stalls: bit_valid=0 while req=1 holds state; there is no timeout.
- Only one of y_valid, frame_done or frame_abort is asserted per cycle per event; y_valid for the last bit coincides with frame_done.
- Reset asserted mid-frame: state is discarded immediately with no done or abort pulse.

Decomposition:
- Shared package seq_pkg holds:
  - FSM state enum (IDLE/RUN/CLR)
  - default N and CNT_W
  - owner index width function
- Sub-module seq_core: s0/s1 flops, sync clear input, enable input, bit input, registered y output.
- Arbiter, FSM and counter live in the top level.

Test Plan:
- Single frame, requester 0, bits 1,1,0,1 (last on the 4th bit) -> y = 1,0,1,0 on consecutive y_valid cycles; frame_done with frame_hits=2; y_owner=0.
- Bits 0,0,0,0 from requester 2 -> y = 0,0,1,0; frame_hits=1; gnt returns to 0 two cycles after the last bit.
- req=4'b1111 held with 1-bit frames -> grants in order 0,1,2,3,0; never the same requester twice in a row.
- Owner drops req after 2 bits (1,1) -> frame_abort pulse with frame_hits=1; no frame_done; next requester granted.
- bit_valid gaps inside a frame 1,_,1,_,0,1 -> same y sequence as the contiguous case (1,0,1,0); no y_valid in gap cycles.
- rst_n pulsed low mid-frame -> all outputs 0 asynchronously; after release, a new frame starts from s0=s1=0 and rr pointer=0.
